neuron_mac: RTL and testbench

- Sequential multiply-accumulate neuron that directly feeds the activation stage.
- Accepts N_INPUTS (data, weight) pairs over a valid/ready stream, adds a bias, and produces one saturated 16-bit unsigned Q8.8 pre-activation sum.
- Presents that sum on a valid/ready output to activation_function, which consumes out_sum as its 16-bit input.

---
 rtl/nn_pkg.sv | 18 +
 rtl/q88_mul.sv | 21 ++
 rtl/neuron_mac.sv | 132 +++++++++++++
 tb/tb_neuron_mac.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: Q8.8 format
// constants, saturation limit and the neuron sequencing states.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  // 1.0 in Q8.8; the activation stage also uses this as its threshold.
  localparam logic [15:0] Q_ONE   = 16'h0100;
  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : nn_pkg

// File: rtl/q88_mul.sv
// Unsigned fixed-point multiply: full DATA_W x DATA_W product, then drop the
// FRAC_W fractional bits (truncation, no rounding). Purely combinational so
// later layer blocks can reuse it inside their own pipelines.
module q88_mul #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic [DATA_W-1:0]        a,
  input  logic [DATA_W-1:0]        b,
  output logic [DATA_W+FRAC_W-1:0] p
);

  logic [2*DATA_W-1:0] prod_s;
  // Fractional bits below the Q8.8 LSB are discarded by design.
  logic                unused_frac_bits_s;

  assign prod_s             = a * b;
  assign p                  = prod_s[2*DATA_W-1:FRAC_W];
  assign unused_frac_bits_s = ^prod_s[FRAC_W-1:0];

endmodule : q88_mul

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron. Loads the bias on start, adds one
// truncated Q8.8 product per accepted beat, and after N_INPUTS beats presents
// the saturated 16-bit sum on a valid/ready output for the activation stage.
module neuron_mac #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = nn_pkg::DATA_W,
  parameter int FRAC_W   = nn_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              busy
);

  import nn_pkg::*;

  // Wide enough that bias plus N_INPUTS maximal products can never wrap.
  localparam int ACC_W = DATA_W + FRAC_W + $clog2(N_INPUTS + 1);
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int PRD_W = DATA_W + FRAC_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [DATA_W-1:0]  out_sum_r;
  logic               out_valid_r;
  logic [PRD_W-1:0]   prod_s;
  logic [ACC_W-1:0]   acc_nxt_s;
  logic               accept_s;
  logic               last_s;

  // Clamp the wide accumulator to the 16-bit output range.
  function automatic logic [DATA_W-1:0] saturate(input logic [ACC_W-1:0] v);
    if (v[ACC_W-1:DATA_W] != {(ACC_W-DATA_W){1'b0}}) begin
      return SAT_MAX;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  q88_mul #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mul (
    .a (in_data),
    .b (in_weight),
    .p (prod_s)
  );

  assign in_ready  = (state_r == ACCUM);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign accept_s  = in_valid && in_ready;
  assign last_s    = (cnt_r == LAST_CNT);
  assign acc_nxt_s = acc_r + {{(ACC_W-PRD_W){1'b0}}, prod_s};

  // State register; reset abandons any evaluation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: start only in IDLE, exit ACCUM on the last beat,
  // leave DONE on the output handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Accumulator, beat counter and registered output; the saturated result is
  // captured from the final accumulate so it is valid the cycle DONE begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_sum_r   <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == DONE);
      if ((state_r == IDLE) && start) begin
        acc_r <= {{(ACC_W-DATA_W){1'b0}}, bias};
        cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        acc_r <= acc_nxt_s;
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (last_s) begin
          out_sum_r <= saturate(acc_nxt_s);
        end
      end
    end
  end

endmodule : neuron_mac

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac (N_INPUTS=4): directed scenarios plus
// randomized evaluations, with a scoreboard queue fed by the driver and
// drained by an independent output monitor.
module tb_neuron_mac;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] in_weight;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        busy;

  int checks;
  int errors;

  logic [15:0] sb[$];
  logic [15:0] d_arr[N];
  logic [15:0] w_arr[N];
  int          bub[N];

  neuron_mac #(.N_INPUTS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bias plus the truncated Q8.8 products, clamped to 16 bits.
  function automatic logic [15:0] ref_sum(input logic [15:0] b);
    longint unsigned acc;
    acc = longint'(b);
    for (int i = 0; i < N; i++) begin
      acc += (longint'(d_arr[i]) * longint'(w_arr[i])) / 256;
    end
    if (acc > 64'd65535) return 16'hFFFF;
    return acc[15:0];
  endfunction

  // Output monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h with no result expected at %0t", out_sum, $time);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (out_sum !== e) begin
          errors++;
          $display("FAIL sb_out_sum: got %h expected %h at %0t", out_sum, e, $time);
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] b, input logic ready_val);
    start     = 1'b1;
    bias      = b;
    out_ready = ready_val;
    @(posedge clk); #1;
    start = 1'b0;
    bias  = 16'($urandom);
  endtask

  task automatic run_beats(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < bub[i]; j++) begin
        in_valid  = 1'b0;
        in_data   = 16'($urandom);
        in_weight = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      in_data   = d_arr[i];
      in_weight = w_arr[i];
      begin
        bit took;
        took = 1'b0;
        for (int t = 0; t < 32 && !took; t++) begin
          @(negedge clk);
          took = in_ready;
          @(posedge clk); #1;
        end
        if (!took) check("beat_accept_timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 64 && busy; t++) @(negedge clk);
    check("idle_reached", busy, 1'b0);
  endtask

  // One full evaluation using d_arr/w_arr/bub; hold>0 stalls out_ready.
  task automatic eval(input logic [15:0] b, input int hold);
    logic [15:0] e;
    e = ref_sum(b);
    do_start(b, (hold == 0));
    run_beats(N);
    sb.push_back(e);
    @(negedge clk);
    check("latency_out_valid", out_valid, 1'b1);
    for (int k = 0; k < hold; k++) begin
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_sum", out_sum, e);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
      @(posedge clk); #1;
      start = (k == 1);
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
    end
    wait_idle();
    if (hold > 1) begin
      @(negedge clk);
      check("start_in_done_ignored", busy, 1'b0);
    end
  endtask

  task automatic fill(input logic [15:0] d, input logic [15:0] w);
    for (int i = 0; i < N; i++) begin
      d_arr[i] = d;
      w_arr[i] = w;
      bub[i]   = 0;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    bias      = 16'h0000;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_weight = 16'h0000;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Beats offered in IDLE are not accepted.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_weight = 16'h5678;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    in_valid = 1'b0;

    // Basic sum.
    fill(16'h0100, 16'h0080);
    eval(16'h0000, 0);
    check("basic_sum", out_sum, 16'h0200);

    // Saturation.
    fill(16'hFF00, 16'hFF00);
    eval(16'h0000, 0);
    check("sat_sum", out_sum, 16'hFFFF);

    // Truncation of tiny products, bias only.
    fill(16'h0001, 16'h0001);
    eval(16'h0100, 0);
    check("trunc_bias_sum", out_sum, 16'h0100);

    // Bubbles: in_valid pattern 1,0,0,1,1,0,1.
    fill(16'h0100, 16'h0080);
    bub[1] = 2;
    bub[3] = 1;
    eval(16'h0000, 0);
    check("bubble_sum", out_sum, 16'h0200);

    // Backpressure with a start pulse during DONE.
    fill(16'h0100, 16'h0080);
    eval(16'h0000, 5);
    check("backpressure_sum", out_sum, 16'h0200);

    // Reset after two accepted beats abandons the evaluation.
    fill(16'h0100, 16'h0080);
    do_start(16'h0000, 1'b1);
    run_beats(2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_sum", out_sum, 16'h0000);
    check("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    eval(16'h0000, 0);
    check("after_rst_sum", out_sum, 16'h0200);

    // Back-to-back: start on the cycle right after the handshake.
    fill(16'h0100, 16'h0100);
    eval(16'h0300, 0);
    check("b2b_sum", out_sum, 16'h0700);

    // Randomized evaluations.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          d_arr[i] = 16'($urandom);
          w_arr[i] = 16'($urandom);
        end else begin
          d_arr[i] = 16'($urandom_range(0, 16'h0400));
          w_arr[i] = 16'($urandom_range(0, 16'h0400));
        end
        bub[i] = $urandom_range(0, 2);
      end
      eval(16'($urandom_range(0, 16'h2000)), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_neuron_mac
